trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Sequences machine-mode trap entry and mret for the pipelined core; drives the CSR trap write port.
//  Samples commit-stage events, arbitrates sync exceptions vs. the timer interrupt, and flushes the pipe.
//  Then commits mepc/mcause (or the mret restore) and redirects fetch. Sits between WB/commit and the CSR file.
// PARAMETERS
//  XLEN        64     data/address width
//  TIMER_CODE  7      interrupt cause code for the machine timer
// PORTS
//  clk              in   1     clock
//  rst_n            in   1     asynchronous, active-low reset
//  commit_valid_i   in   1     instruction present at commit this cycle
//  commit_pc_i      in   XLEN  pc of the committing instruction
//  illegal_i        in   1     commit instr is illegal
//  ebreak_i         in   1     commit instr is ebreak
//  ecall_i          in   1     commit instr is ecall
//  mret_i           in   1     commit instr is mret
//  irq_timer_i      in   1     level timer interrupt pending
//  mstatus_mie_i    in   1     global interrupt enable from CSR
//  mie_mtie_i       in   1     timer interrupt enable from CSR
//  mtvec_i          in   XLEN  current mtvec from CSR
//  mepc_i           in   XLEN  current mepc from CSR
//  pipe_idle_i      in   1     pipeline drained after flush (handshake)
//  redirect_ready_i in   1     fetch accepted redirect
//  commit_kill_o    out  1     suppress retirement of the commit instr (combinational, IDLE only)
//  flush_o          out  1     flush all stages younger than commit
//  stall_o          out  1     freeze fetch/decode
//  trap_we_o        out  1     one-cycle strobe: CSR writes mepc/mcause, MPIE<=MIE, MIE<=0
//  mret_we_o        out  1     one-cycle strobe: CSR sets MIE<=MPIE, MPIE<=1
//  trap_mepc_o      out  XLEN  value for mepc ([1:0] forced 0)
//  trap_mcause_o    out  XLEN  value for mcause; bit XLEN-1 = interrupt
//  redirect_valid_o out  1     new fetch pc valid
//  redirect_pc_o    out  XLEN  new fetch pc
//  busy_o           out  1     state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; every output and internal cause/pc/target register = 0.
//  - Reset mid-sequence aborts immediately to IDLE; no partial CSR strobe is issued.
//  - FSM: IDLE -> FLUSH -> WRITE -> REDIRECT -> IDLE.
//  - IDLE: event = commit_valid_i & (illegal|ebreak|ecall|mret|irq_take),
//    where irq_take = irq_timer_i & mstatus_mie_i & mie_mtie_i.
//    On event: commit_kill_o=1 that same cycle, except for mret; capture pc, cause, target; go to FLUSH.
//  - Priority: illegal(cause 2) > ebreak(3) > ecall(11) > mret > timer irq.
//    A pending irq is never taken in a cycle that carries a sync event or mret; it waits.
//  - Interrupt mcause = {1'b1, (XLEN-1)'(TIMER_CODE)}. mepc = commit_pc_i, since the instruction is killed.
//  - FLUSH: flush_o=1, stall_o=1. Stays in FLUSH until pipe_idle_i=1 (min 1 cycle), then goes to WRITE.
//  - WRITE: exactly 1 cycle. trap_we_o=1 for a trap, or mret_we_o=1 for mret; never both. stall_o=1.
//  - REDIRECT: redirect_valid_o=1, stall_o=1. redirect_pc_o is held stable until redirect_ready_i=1, then IDLE.
//  - Targets: trap -> {mtvec_i[XLEN-1:2],2'b00}; mret -> {mepc_i[XLEN-1:2],2'b00}.
//    Targets are sampled at the IDLE capture and not re-read afterwards.
//  - Events and commit_valid_i are ignored outside IDLE; commit_kill_o=0 outside IDLE.
//  - Minimum trap latency is 4 cycles: event cycle N, FLUSH N+1, WRITE N+2, REDIRECT N+3.
//    This holds when pipe_idle_i and redirect_ready_i are already high.
// CONFIGURATION
//  TRAP_VECTORED_EN defined:
//    if mtvec_i[1:0]==2'b01 and the cause is an interrupt, target = {mtvec_i[XLEN-1:2],2'b00} + 4*TIMER_CODE.
//    Sync exceptions still go to the base.
//  TRAP_VECTORED_EN undefined: mtvec_i[1:0] is ignored; every trap goes to the base.
// TESTING
//  - ecall @pc=0x8000_0010, mtvec=0x8000_0100, idle/ready high
//      -> kill same cycle; trap_we at +2 with mepc=0x8000_0010, mcause=11; redirect 0x8000_0100 at +3.
//  - illegal+ecall same cycle -> mcause=2; a single trap_we pulse.
//  - irq_timer=1, mie=1, mtie=1, commit pc=0x8000_0020
//      -> mcause=0x8000_0000_0000_0007, mepc=0x8000_0020.
//  - same irq with mstatus_mie=0 -> no event; busy_o stays 0.
//  - mret with mepc=0x8000_0024
//      -> no kill; mret_we pulse; redirect 0x8000_0024; hold redirect_ready low 3 cycles and check the pc stays stable.
//  - rst_n low during FLUSH -> all outputs 0 asynchronously; no trap_we after release.
//  - TRAP_VECTORED_EN defined, mtvec=0x8000_0101, timer irq -> redirect 0x8000_011C.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: IDLE -> FLUSH -> WRITE -> REDIRECT -> IDLE.
// Define TRAP_VECTORED_EN to vector timer interrupts when mtvec mode is 2'b01.
module trap_sequencer #(
   parameter int XLEN       = 64,
   parameter int TIMER_CODE = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            commit_valid_i,
   input  logic [XLEN-1:0] commit_pc_i,
   input  logic            illegal_i,
   input  logic            ebreak_i,
   input  logic            ecall_i,
   input  logic            mret_i,
   input  logic            irq_timer_i,
   input  logic            mstatus_mie_i,
   input  logic            mie_mtie_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            pipe_idle_i,
   input  logic            redirect_ready_i,
   output logic            commit_kill_o,
   output logic            flush_o,
   output logic            stall_o,
   output logic            trap_we_o,
   output logic            mret_we_o,
   output logic [XLEN-1:0] trap_mepc_o,
   output logic [XLEN-1:0] trap_mcause_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            busy_o
);

   typedef enum logic [1:0] {IDLE, FLUSH, WRITE, REDIRECT} state_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   state_t          state;
   logic            is_mret_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] target_q;

   logic            irq_take;
   logic            sync_evt;
   logic            take_mret;
   logic            evt;
   logic [XLEN-1:0] base;
   logic [XLEN-1:0] cause_d;
   logic [XLEN-1:0] target_d;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      irq_take  = irq_timer_i & mstatus_mie_i & mie_mtie_i;
      sync_evt  = illegal_i | ebreak_i | ecall_i;
      take_mret = mret_i & ~sync_evt;
      evt       = commit_valid_i & (sync_evt | mret_i | irq_take);
      base      = mtvec_i & ALIGN_MASK;
      cause_d   = '0;
      target_d  = base;
      if (illegal_i)      cause_d = XLEN'(2);
      else if (ebreak_i)  cause_d = XLEN'(3);
      else if (ecall_i)   cause_d = XLEN'(11);
      else if (mret_i)    target_d = mepc_i & ALIGN_MASK;
      else begin
         cause_d = {1'b1, (XLEN-1)'(TIMER_CODE)};
`ifdef TRAP_VECTORED_EN
         if (mtvec_i[1:0] == 2'b01) target_d = base + XLEN'(4 * TIMER_CODE);
`endif
      end
   end

   // Gated by rst_n so that every output reads 0 while reset is held.
   assign commit_kill_o = rst_n & (state == IDLE) & evt & ~take_mret;

   assign trap_mepc_o   = pc_q;
   assign trap_mcause_o = cause_q;
   assign redirect_pc_o = target_q;

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         is_mret_q        <= 1'b0;
         pc_q             <= '0;
         cause_q          <= '0;
         target_q         <= '0;
         flush_o          <= 1'b0;
         stall_o          <= 1'b0;
         trap_we_o        <= 1'b0;
         mret_we_o        <= 1'b0;
         redirect_valid_o <= 1'b0;
         busy_o           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (evt) begin
                  state     <= FLUSH;
                  flush_o   <= 1'b1;
                  stall_o   <= 1'b1;
                  busy_o    <= 1'b1;
                  is_mret_q <= take_mret;
                  pc_q      <= commit_pc_i & ALIGN_MASK;
                  cause_q   <= cause_d;
                  target_q  <= target_d;
               end
            end
            FLUSH: begin
               if (pipe_idle_i) begin
                  state     <= WRITE;
                  flush_o   <= 1'b0;
                  trap_we_o <= ~is_mret_q;
                  mret_we_o <= is_mret_q;
               end
            end
            WRITE: begin
               state            <= REDIRECT;
               trap_we_o        <= 1'b0;
               mret_we_o        <= 1'b0;
               redirect_valid_o <= 1'b1;
            end
            REDIRECT: begin
               if (redirect_ready_i) begin
                  state            <= IDLE;
                  redirect_valid_o <= 1'b0;
                  stall_o          <= 1'b0;
                  busy_o           <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: randomized commit events vs. a priority/arithmetic model.
// Honors TRAP_VECTORED_EN the same way the design does.
module tb_trap_sequencer;

   typedef struct {
      logic        v, il, eb, ec, mr, irq, mie, mtie;
      logic [63:0] pc, tvec, epc;
   } stim_t;

   typedef struct {
      bit          is_mret;
      logic [63:0] mepc;
      logic [63:0] mcause;
      logic [63:0] target;
      bit          strobed;
   } exp_t;

`ifdef TRAP_VECTORED_EN
   localparam bit VECT = 1'b1;
`else
   localparam bit VECT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        commit_valid_i = 1'b0;
   logic [63:0] commit_pc_i = '0;
   logic        illegal_i = 1'b0, ebreak_i = 1'b0, ecall_i = 1'b0, mret_i = 1'b0;
   logic        irq_timer_i = 1'b0, mstatus_mie_i = 1'b0, mie_mtie_i = 1'b0;
   logic [63:0] mtvec_i = '0, mepc_i = '0;
   logic        pipe_idle_i = 1'b1, redirect_ready_i = 1'b1;
   logic        commit_kill_o, flush_o, stall_o, trap_we_o, mret_we_o;
   logic [63:0] trap_mepc_o, trap_mcause_o, redirect_pc_o;
   logic        redirect_valid_o, busy_o;

   int   checks = 0;
   int   errors = 0;
   int   hs_mode = 0;
   exp_t exp_q[$];
   bit          hold_wait = 1'b0;
   logic [63:0] hold_pc = '0;

   trap_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
      .illegal_i(illegal_i), .ebreak_i(ebreak_i), .ecall_i(ecall_i), .mret_i(mret_i),
      .irq_timer_i(irq_timer_i), .mstatus_mie_i(mstatus_mie_i), .mie_mtie_i(mie_mtie_i),
      .mtvec_i(mtvec_i), .mepc_i(mepc_i),
      .pipe_idle_i(pipe_idle_i), .redirect_ready_i(redirect_ready_i),
      .commit_kill_o(commit_kill_o), .flush_o(flush_o), .stall_o(stall_o),
      .trap_we_o(trap_we_o), .mret_we_o(mret_we_o),
      .trap_mepc_o(trap_mepc_o), .trap_mcause_o(trap_mcause_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural priority rules in plain arithmetic.
   function automatic void model(input stim_t s, output bit ev, output bit kill, output exp_t e);
      bit sync_ev = s.il | s.eb | s.ec;
      bit take    = s.irq & s.mie & s.mtie;
      ev        = s.v & (sync_ev | s.mr | take);
      e.is_mret = !sync_ev && s.mr;
      kill      = ev && !e.is_mret;
      e.mepc    = s.pc & ~64'h3;
      e.strobed = 1'b0;
      if (s.il)      e.mcause = 64'd2;
      else if (s.eb) e.mcause = 64'd3;
      else if (s.ec) e.mcause = 64'd11;
      else           e.mcause = 64'h8000_0000_0000_0007;
      if (e.is_mret)
         e.target = s.epc & ~64'h3;
      else if (!sync_ev && VECT && s.tvec[1:0] == 2'b01)
         e.target = (s.tvec & ~64'h3) + 64'd28;
      else
         e.target = s.tvec & ~64'h3;
   endfunction

   task automatic quiet();
      commit_valid_i = 0; illegal_i = 0; ebreak_i = 0; ecall_i = 0; mret_i = 0;
      irq_timer_i = 0;
   endtask

   task automatic junk();
      commit_valid_i = 1'($urandom); illegal_i = 1'($urandom); ebreak_i = 1'($urandom);
      ecall_i = 1'($urandom); mret_i = 1'($urandom); irq_timer_i = 1'($urandom);
      mstatus_mie_i = 1'($urandom); mie_mtie_i = 1'($urandom);
      commit_pc_i = {$urandom, $urandom}; mtvec_i = {$urandom, $urandom}; mepc_i = {$urandom, $urandom};
   endtask

   // Called just after a posedge with the DUT idle; returns just after the next posedge.
   task automatic issue(input stim_t s);
      bit ev, kill;
      exp_t e;
      model(s, ev, kill, e);
      commit_valid_i = s.v; illegal_i = s.il; ebreak_i = s.eb; ecall_i = s.ec; mret_i = s.mr;
      irq_timer_i = s.irq; mstatus_mie_i = s.mie; mie_mtie_i = s.mtie;
      commit_pc_i = s.pc; mtvec_i = s.tvec; mepc_i = s.epc;
      if (ev) exp_q.push_back(e);
      @(negedge clk);
      check("commit_kill", commit_kill_o, kill);
      @(posedge clk); #1;
      quiet();
      check("busy_after_event", busy_o, ev);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < 200) begin
         junk();
         @(posedge clk); #1;
         n++;
      end
      if (busy_o) check("idle_timeout", busy_o, 1'b0);
      quiet();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_kill"}, commit_kill_o, 0);
      check({tag, "_flush"}, flush_o, 0);
      check({tag, "_stall"}, stall_o, 0);
      check({tag, "_trap_we"}, trap_we_o, 0);
      check({tag, "_mret_we"}, mret_we_o, 0);
      check({tag, "_mepc"}, trap_mepc_o, 0);
      check({tag, "_mcause"}, trap_mcause_o, 0);
      check({tag, "_rvalid"}, redirect_valid_o, 0);
      check({tag, "_rpc"}, redirect_pc_o, 0);
      check({tag, "_busy"}, busy_o, 0);
   endtask

   function automatic stim_t mk(input logic v, il, eb, ec, mr, irq, mie, mtie,
                                input logic [63:0] pc, tvec, epc);
      stim_t s;
      s.v = v; s.il = il; s.eb = eb; s.ec = ec; s.mr = mr;
      s.irq = irq; s.mie = mie; s.mtie = mtie; s.pc = pc; s.tvec = tvec; s.epc = epc;
      return s;
   endfunction

   // Handshake drivers, offset from the stimulus process so ordering is deterministic.
   always @(posedge clk) begin
      #2;
      case (hs_mode)
         0: begin
            pipe_idle_i      = ($urandom_range(0, 2) != 0);
            redirect_ready_i = ($urandom_range(0, 2) != 0);
         end
         1: begin pipe_idle_i = 1; redirect_ready_i = 1; end
         2: begin pipe_idle_i = 0; redirect_ready_i = 1; end
         default: begin pipe_idle_i = 1; redirect_ready_i = 0; end
      endcase
   end

   // Monitor: pops the scoreboard whenever the DUT presents a strobe or an accepted redirect.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_wait = 1'b0;
      end else begin
         if (trap_we_o || mret_we_o) begin
            check("strobe_exclusive", trap_we_o & mret_we_o, 1'b0);
            check("strobe_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               check("strobe_kind_mret", mret_we_o, exp_q[0].is_mret);
               check("strobe_single", exp_q[0].strobed, 1'b0);
               if (trap_we_o) begin
                  check("trap_mepc", trap_mepc_o, exp_q[0].mepc);
                  check("trap_mcause", trap_mcause_o, exp_q[0].mcause);
               end
               exp_q[0].strobed = 1'b1;
            end
         end
         if (redirect_valid_o) begin
            if (hold_wait) check("redirect_stable", redirect_pc_o, hold_pc);
            if (redirect_ready_i) begin
               check("redirect_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  check("redirect_after_strobe", exp_q[0].strobed, 1'b1);
                  check("redirect_pc", redirect_pc_o, exp_q[0].target);
                  void'(exp_q.pop_front());
               end
            end
         end
         hold_wait = redirect_valid_o && !redirect_ready_i;
         hold_pc   = redirect_pc_o;
      end
   end

   initial begin
      #3;
      check_zero("reset");
      #9 rst_n = 1;
      hs_mode = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;

      // ecall with minimum latency
      issue(mk(1, 0, 0, 1, 0, 0, 0, 0, 64'h8000_0010, 64'h8000_0100, 64'h0));
      @(negedge clk);
      check("lat_flush", flush_o, 1'b1);
      check("lat_no_we_early", trap_we_o, 1'b0);
      @(negedge clk);
      check("lat_trap_we", trap_we_o, 1'b1);
      check("lat_stall_write", stall_o, 1'b1);
      @(negedge clk);
      check("lat_redirect_valid", redirect_valid_o, 1'b1);
      check("lat_redirect_pc", redirect_pc_o, 64'h8000_0100);
      @(posedge clk); #1;
      wait_idle();

      // illegal + ecall together: illegal wins, one strobe
      issue(mk(1, 1, 0, 1, 0, 0, 0, 0, 64'h8000_0014, 64'h8000_0200, 64'h0));
      wait_idle();

      // timer interrupt taken
      issue(mk(1, 0, 0, 0, 0, 1, 1, 1, 64'h8000_0020, 64'h8000_0100, 64'h0));
      wait_idle();

      // same interrupt masked globally: nothing happens
      issue(mk(1, 0, 0, 0, 0, 1, 0, 1, 64'h8000_0020, 64'h8000_0100, 64'h0));
      repeat (3) begin
         @(negedge clk);
         check("masked_irq_busy", busy_o, 1'b0);
      end
      @(posedge clk); #1;

      // vectored-mode mtvec with timer interrupt
      issue(mk(1, 0, 0, 0, 0, 1, 1, 1, 64'h8000_0030, 64'h8000_0101, 64'h0));
      wait_idle();

      // mret with redirect held off for 3 cycles
      hs_mode = 3;
      @(posedge clk); #1;
      issue(mk(1, 0, 0, 0, 1, 1, 1, 1, 64'h8000_0040, 64'h8000_0100, 64'h8000_0024));
      begin
         int n = 0;
         while (!redirect_valid_o && n < 50) begin @(posedge clk); #1; n++; end
         check("mret_redirect_seen", redirect_valid_o, 1'b1);
      end
      repeat (3) begin
         @(negedge clk);
         check("mret_hold_pc", redirect_pc_o, 64'h8000_0024);
         check("mret_hold_valid", redirect_valid_o, 1'b1);
      end
      hs_mode = 1;
      @(posedge clk); #1;
      wait_idle();

      // reset during FLUSH aborts without a strobe
      hs_mode = 2;
      @(posedge clk); #1;
      issue(mk(1, 1, 0, 0, 0, 0, 0, 0, 64'h8000_0050, 64'h8000_0100, 64'h0));
      #2 rst_n = 0;
      exp_q.delete();
      #1 check_zero("midreset");
      @(posedge clk);
      #4 rst_n = 1;
      hs_mode = 1;
      repeat (8) begin
         @(negedge clk);
         check("post_reset_busy", busy_o, 1'b0);
      end
      @(posedge clk); #1;

      // randomized traffic with random handshakes
      hs_mode = 0;
      for (int i = 0; i < 300; i++) begin
         stim_t s;
         s = mk(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0), {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom});
         issue(s);
         wait_idle();
      end

      hs_mode = 1;
      repeat (5) @(posedge clk);
      #1 check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
